// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
// FSM state encoding for the FIFO-fed transmitter, the idle line level and
// the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side connection between a byte FIFO and its consumer.
//   fifo_rd    : one-cycle pop strobe from the consumer
//   fifo_empty : FIFO has no data
//   fifo_dout  : FIFO read data
// Handshake: the consumer may assert fifo_rd for one cycle only after it saw
// fifo_empty=0 at the deciding clock edge; fifo_dout holds the popped byte in
// the cycle after the fifo_rd cycle.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              fifo_rd;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  // master = consumer (transmitter), slave = FIFO
  modport master (output fifo_rd, input fifo_empty, input fifo_dout);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_dout);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : forces the count back to 0 at the next edge
//   tick         : high for one cycle while the count is CLKS_PER_BIT-1
//   count        : current count, 0..CLKS_PER_BIT-1
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick  = (count_q == LAST);
  assign count = count_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a byte FIFO and sends them as 8N1 UART
// frames, LSB first.
//   clock, reset : clock and asynchronous active-high reset
//   enable       : allows a new frame to start (looked at in IDLE and at the
//                  last stop-bit cycle only)
//   fifo         : FIFO read side (fifo_rd out, fifo_empty / fifo_dout in)
//   tx           : serial line, idles high
//   busy         : high from POP through the end of the stop bit
//   done         : one-cycle pulse in the last cycle of each stop bit
//   dbg_state    : current FSM state
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  state_t            state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              tx_q,      tx_d;
  logic              rd_q,      rd_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic              baud_clear;
  logic              baud_tick;
  logic [CNT_W-1:0]  baud_cnt;
  logic              start_ok;

  // Clearing during LOAD makes the start bit last exactly one full period.
  assign baud_clear = (state_q == LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick),
    .count (baud_cnt)
  );

  assign start_ok = enable && !fifo.fifo_empty;

  // tx is registered: each branch loads the level for the next bit slot,
  // so tx always equals the LSB of the shift register while in DATA.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    rd_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (start_ok) begin
          state_d = POP;
          rd_d    = 1'b1;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo.fifo_dout;
        bit_idx_d = '0;
        tx_d      = 1'b0;
        state_d   = START;
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (start_ok) begin
            state_d = POP;
            rd_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    // Count C-2 in STOP means the next cycle is the last one of the stop bit.
    done_d = (state_q == STOP) && (baud_cnt == PRE_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo.fifo_rd = rd_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule
